// File: rtl/demux_1x4_stream.sv
// 1-to-4 streaming demultiplexer: steers each input beat into one of four
// one-entry output lanes, chosen by an external select or a round-robin pointer.
module demux_1x4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [1:0]         sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         rr_ptr,
    output logic [15:0]        accept_cnt
);

    // Handshakes: a beat moves on any edge where valid and ready are both high;
    // ready never depends on valid of the same interface, and a producer holding
    // valid keeps its data stable until the transfer happens.

    logic [1:0] tgt;
    logic       accept;

    always_comb begin
        tgt      = mode ? rr_ptr : sel;
        in_ready = !out_valid[tgt] || out_ready[tgt];
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= '0;
            out_data   <= '0;
            rr_ptr     <= '0;
            accept_cnt <= '0;
        end else begin
            // A load on a lane takes priority over its drain so a lane can
            // be refilled on the same edge its consumer takes the old beat.
            for (int i = 0; i < 4; i++) begin
                if (accept && (tgt == i[1:0])) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept) begin
                accept_cnt <= accept_cnt + 16'd1;
                if (mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: a per-cycle lane model plus
// directed vectors with hand-computed expectations.
module tb_demux_1x4_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [1:0]     sel = '0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = '0;
    logic [1:0]     rr_ptr;
    logic [15:0]    accept_cnt;

    int tests = 0;
    int fails = 0;

    demux_1x4_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rr_ptr     (rr_ptr),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i);
        return out_data[i*W +: W];
    endfunction

    // Behavioural model: each lane is a slot that is either empty or holds one
    // beat; the pointer counts accepted auto-mode beats modulo 4.
    int m_full[4];
    int m_data[4];
    int m_ptr;
    int m_cnt;

    always @(negedge clk) begin
        int t;
        bit rdy;
        bit acc;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 0;
                m_data[i] = 0;
            end
            m_ptr = 0;
            m_cnt = 0;
        end
        t   = mode ? m_ptr : int'(sel);
        rdy = (m_full[t] == 0) || out_ready[t];
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lane%0d_valid", i), 32'(out_valid[i]), 32'(m_full[i]));
            check($sformatf("lane%0d_data", i), 32'(lane(i)), 32'(m_data[i]));
        end
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        check("accept_cnt", 32'(accept_cnt), 32'(m_cnt));
        if (!rst) begin
            acc = in_valid && rdy;
            for (int i = 0; i < 4; i++) begin
                if (acc && i == t) begin
                    m_full[i] = 1;
                    m_data[i] = int'(in_data);
                end else if (m_full[i] == 1 && out_ready[i]) begin
                    m_full[i] = 0;
                end
            end
            if (acc) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (mode) m_ptr = (m_ptr + 1) % 4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic [1:0] s, input logic [W-1:0] d);
        mode     = m;
        sel      = s;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        check("beat_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cnt", 32'(accept_cnt), 32'h0);
        check("rst_ptr", 32'(rr_ptr), 32'h0);
        rst = 1'b0;
        step();

        // Manual mode, all consumers ready.
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, 2'(k), 8'hA0 + 8'(k));
            check("man_lane_data", 32'(lane(k)), 32'(8'hA0 + 8'(k)));
            check("man_lane_valid", 32'(out_valid[k]), 32'd1);
        end
        check("man_ptr", 32'(rr_ptr), 32'd0);
        check("man_cnt", 32'(accept_cnt), 32'd4);

        // Auto mode round-robin.
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, 2'd0, 8'h10 + 8'(k));
            check("auto_lane_data", 32'(lane(k % 4)), 32'(8'h10 + 8'(k)));
        end
        check("auto_ptr", 32'(rr_ptr), 32'd0);
        check("auto_cnt", 32'(accept_cnt), 32'd12);

        // Backpressure on lane 2.
        out_ready = 4'b1011;
        beat(1'b0, 2'd2, 8'h55);
        check("bp_lane2_first", 32'(lane(2)), 32'h55);
        in_data  = 8'h66;
        in_valid = 1'b1;
        #1;
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        step();
        check("bp_hold_data", 32'(lane(2)), 32'h55);
        check("bp_hold_valid", 32'(out_valid[2]), 32'd1);
        out_ready = 4'b1111;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_lane2_second", 32'(lane(2)), 32'h66);
        check("bp_cnt", 32'(accept_cnt), 32'd14);

        // Auto-mode stall on a full lane 1, then manual bypass to lane 3.
        out_ready = 4'b1101;
        beat(1'b1, 2'd0, 8'h20);
        beat(1'b0, 2'd1, 8'h21);
        check("stall_setup_ptr", 32'(rr_ptr), 32'd1);
        mode     = 1'b1;
        in_data  = 8'h30;
        in_valid = 1'b1;
        #1;
        check("stall_ready", 32'(in_ready), 32'd0);
        step();
        check("stall_ready_hold", 32'(in_ready), 32'd0);
        check("stall_ptr", 32'(rr_ptr), 32'd1);
        check("stall_lane1", 32'(lane(1)), 32'h21);
        mode    = 1'b0;
        sel     = 2'd3;
        in_data = 8'h77;
        #1;
        check("bypass_ready", 32'(in_ready), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("bypass_lane3", 32'(lane(3)), 32'h77);
        check("bypass_ptr", 32'(rr_ptr), 32'd1);
        step();
        check("pre_rst_valid", 32'(out_valid), 32'b1010);
        check("pre_rst_cnt", 32'(accept_cnt), 32'd17);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_ptr", 32'(rr_ptr), 32'h0);
        check("async_rst_cnt", 32'(accept_cnt), 32'h0);
        step();
        rst = 1'b0;
        step();

        // Counter wrap.
        mode      = 1'b1;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            in_data = 8'(k);
            step();
        end
        check("wrap_preload", 32'(accept_cnt), 32'hFFFF);
        in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        check("wrap_zero", 32'(accept_cnt), 32'h0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
